game_tick_ctrl: RTL and testbench

//   Run/pause/stop controller for the game-speed tick.
//   - Emits one-cycle game ticks from a programmable-period counter.
//   - Shortens the period stepwise as play continues, so the ball speeds up.
//   - Sits between the top-level game FSM (start/stop/pause) and the ball/paddle update logic (tick).

---
 rtl/game_tick_ctrl.sv | 146 ++++++++++++++
 tb/tb_game_tick_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: run/pause/stop controller for the game-speed tick.
// Counts up to a programmable period and emits a one-cycle tick on wrap.
// The period shrinks by STEP every RAMP_TICKS ticks, down to PERIOD_MIN,
// so the ball speeds up the longer play continues.
module game_tick_ctrl #(
  parameter int CW          = 32,
  parameter int PERIOD_INIT = 12000,
  parameter int PERIOD_MIN  = 3000,
  parameter int STEP        = 1000,
  parameter int RAMP_TICKS  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  output logic          tick,
  output logic [3:0]    level,
  output logic          running,
  output logic [CW-1:0] period_out
);

  localparam int RW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

  localparam logic [CW-1:0] P_INIT      = CW'(PERIOD_INIT);
  localparam logic [CW-1:0] P_MIN       = CW'(PERIOD_MIN);
  localparam logic [CW-1:0] P_STEP      = CW'(STEP);
  // One bit wider so PERIOD_MIN+STEP cannot wrap for wide periods.
  localparam logic [CW:0]   P_MIN_STEP  = (CW+1)'(PERIOD_MIN) + (CW+1)'(STEP);
  localparam logic [RW-1:0] RAMP_LAST   = RW'(RAMP_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [RW-1:0] ramp_r, ramp_s;
  logic [CW-1:0] period_r, period_s;
  logic [3:0]    level_r, level_s;
  logic          tick_r, tick_s;
  logic          running_r;

  // Next period after a speed-up: step down, clamp to the floor, never underflow.
  function automatic logic [CW-1:0] ramp_period(input logic [CW-1:0] p);
    logic [CW-1:0] r;
    if ({1'b0, p} >= P_MIN_STEP) begin
      r = p - P_STEP;
    end else if (p > P_MIN) begin
      r = P_MIN;
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Next-state and datapath decode; stop beats start beats pause.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ramp_s   = ramp_r;
    period_s = period_r;
    level_s  = level_r;
    tick_s   = 1'b0;
    if (stop) begin
      state_s = ST_IDLE;
      cnt_s   = {CW{1'b0}};
      ramp_s  = {RW{1'b0}};
    end else if (start) begin
      state_s  = ST_RUN;
      cnt_s    = {CW{1'b0}};
      ramp_s   = {RW{1'b0}};
      period_s = P_INIT;
      level_s  = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_RUN: begin
          if (pause) begin
            // Pause wins over a wrap on the same edge; cnt is held.
            state_s = ST_PAUSED;
          end else if (cnt_r == period_r) begin
            cnt_s  = {CW{1'b0}};
            tick_s = 1'b1;
            if (ramp_r == RAMP_LAST) begin
              ramp_s   = {RW{1'b0}};
              period_s = ramp_period(period_r);
              // Level only counts speed-ups that actually happened.
              if ((period_s != period_r) && (level_r != 4'd15)) begin
                level_s = level_r + 4'd1;
              end else begin
                level_s = level_r;
              end
            end else begin
              ramp_s = ramp_r + RW'(1'b1);
            end
          end else begin
            cnt_s = cnt_r + CW'(1'b1);
          end
        end
        ST_PAUSED: begin
          // Resume takes one edge; counting continues on the following one.
          if (pause) begin
            state_s = ST_PAUSED;
          end else begin
            state_s = ST_RUN;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers; running follows the next state so it lines up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      ramp_r    <= {RW{1'b0}};
      period_r  <= P_INIT;
      level_r   <= 4'd0;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      ramp_r    <= ramp_s;
      period_r  <= period_s;
      level_r   <= level_s;
      tick_r    <= tick_s;
      running_r <= (state_s == ST_RUN);
    end
  end

  assign tick       = tick_r;
  assign level      = level_r;
  assign running    = running_r;
  assign period_out = period_r;

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb_game_tick_ctrl: directed scenarios plus randomized stimulus, checked
// every cycle against a countdown-style reference model of the tick rules.
module tb_game_tick_ctrl;

  localparam int CW   = 16;
  localparam int PI   = 9;
  localparam int PMIN = 3;
  localparam int STP  = 2;
  localparam int RT   = 2;

  logic          clk = 1'b0;
  logic          reset, start, stop, pause;
  logic          tick;
  logic [3:0]    level;
  logic          running;
  logic [CW-1:0] period_out;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0=idle 1=run 2=paused; rem = cycles left before wrap.
  int m_mode, m_rem, m_period, m_level, m_ticks;
  bit m_tick;

  game_tick_ctrl #(
    .CW(CW), .PERIOD_INIT(PI), .PERIOD_MIN(PMIN), .STEP(STP), .RAMP_TICKS(RT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .tick(tick), .level(level), .running(running), .period_out(period_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_period = PI; m_level = 0; m_ticks = 0; m_tick = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit pa);
    int np;
    m_tick = 1'b0;
    if (sp) begin
      m_mode = 0; m_ticks = 0;
    end else if (st) begin
      m_mode = 1; m_period = PI; m_rem = PI; m_level = 0; m_ticks = 0;
    end else if (m_mode == 1) begin
      if (pa) m_mode = 2;
      else if (m_rem == 0) begin
        m_tick = 1'b1;
        m_ticks++;
        if (m_ticks % RT == 0) begin
          np = m_period - STP;
          if (np < PMIN) np = PMIN;
          if (np < m_period && m_level < 15) m_level++;
          if (np < m_period) m_period = np;
        end
        m_rem = m_period;
      end else begin
        m_rem--;
      end
    end else if (m_mode == 2) begin
      if (!pa) m_mode = 1;
    end
  endtask

  task automatic check_all();
    chk("tick", {31'd0, tick}, {31'd0, m_tick});
    chk("level", {28'd0, level}, m_level);
    chk("running", {31'd0, running}, (m_mode == 1) ? 32'd1 : 32'd0);
    chk("period_out", {16'd0, period_out}, m_period);
  endtask

  // One clock: model follows the edge, outputs are compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_edge(start, stop, pause);
    #1;
    check_all();
  endtask

  task automatic wait_tick(output int gap);
    gap = -1;
    for (int i = 1; i <= 60; i++) begin
      cycle();
      if (tick === 1'b1) begin
        gap = i;
        return;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  int gap;
  int exp_gaps[9] = '{10, 10, 8, 8, 6, 6, 4, 4, 4};

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_period", {16'd0, period_out}, 32'd9);

    // 1: tick spacing and speed ramp down to the floor
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      wait_tick(gap);
      chk("t1_gap", gap, exp_gaps[k]);
      if (k == 1) begin
        chk("t1_period7", {16'd0, period_out}, 32'd7);
        chk("t1_level1", {28'd0, level}, 32'd1);
      end else if (k == 5) begin
        chk("t1_period3", {16'd0, period_out}, 32'd3);
        chk("t1_level3", {28'd0, level}, 32'd3);
      end
    end
    chk("t1_level_held", {28'd0, level}, 32'd3);

    // 2: pause mid-count at cnt=4
    pulse_start();
    repeat (4) cycle();
    pause = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t2_running", {31'd0, running}, 32'd0);
    end
    pause = 1'b0;
    wait_tick(gap);
    chk("t2_gap_seen", (gap > 0) ? 32'd1 : 32'd0, 32'd1);

    // 3: pause on the wrap edge suppresses the tick until resume
    pulse_start();
    repeat (9) cycle();
    pause = 1'b1;
    repeat (3) cycle();
    chk("t3_no_tick", {31'd0, tick}, 32'd0);
    pause = 1'b0;
    cycle();
    cycle();
    chk("t3_tick_resume", {31'd0, tick}, 32'd1);

    // 4: start+stop together -> idle; then start alone
    repeat (3) cycle();
    start = 1'b1; stop = 1'b1;
    cycle();
    start = 1'b0; stop = 1'b0;
    chk("t4_idle", {31'd0, running}, 32'd0);
    repeat (12) cycle();
    pulse_start();
    chk("t4_period", {16'd0, period_out}, 32'd9);
    chk("t4_level", {28'd0, level}, 32'd0);
    wait_tick(gap);
    chk("t4_gap", gap, 32'd10);

    // 5: restart from level 2
    repeat (3) begin
      wait_tick(gap);
    end
    chk("t5_level2", {28'd0, level}, 32'd2);
    repeat (2) cycle();
    pulse_start();
    chk("t5_period", {16'd0, period_out}, 32'd9);
    chk("t5_level", {28'd0, level}, 32'd0);
    wait_tick(gap);
    chk("t5_gap", gap, 32'd10);

    // 6: asynchronous reset between edges
    wait_tick(gap);
    repeat (3) cycle();
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("t6_tick", {31'd0, tick}, 32'd0);
    chk("t6_running", {31'd0, running}, 32'd0);
    chk("t6_period", {16'd0, period_out}, 32'd9);
    repeat (2) cycle();
    reset = 1'b0;
    repeat (15) cycle();
    chk("t6_idle", {31'd0, running}, 32'd0);

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      stop  = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 79) == 0) || (m_mode == 0 && $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) pause = ~pause;
      if ($urandom_range(0, 399) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        cycle();
        reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
